// File: rtl/rope_sequencer.sv
// rope_sequencer: schedules a bank of horizontally moving rope movers.
// It releases the ropes one at a time at level start and gates their frame
// ticks while paused. It also pulses a per-rope direction toggle when a rope
// reaches a playfield limit. Each rope's activity, direction and toggle state
// lives in its own lane instance.

module rope_lane #(
  parameter bit ODD         = 1'b0,
  parameter int LEFT_LIMIT  = 32,
  parameter int RIGHT_BOUND = 560
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        clear,
  input  logic        release_i,
  input  logic        run_en,
  input  logic        check_en,
  input  logic [10:0] x,
  output logic        active_o,
  output logic        toggle_o
);
  localparam logic signed [10:0] LB = 11'(LEFT_LIMIT);
  localparam logic signed [10:0] RB = 11'(RIGHT_BOUND);

  logic act_q, act_d, dir_q, dir_d, tog_q, tog_d, init_q, init_d;
  logic hit;

  // Limit hit for the current direction (0 = right, 1 = left), signed X.
  always_comb begin
    hit = dir_q ? ($signed(x) <= LB) : ($signed(x) >= RB);
  end

  // Release, initial odd-rope alignment toggle and limit toggles.
  // A pending alignment toggle consumes that rope's toggle slot.
  always_comb begin
    act_d  = act_q;
    dir_d  = dir_q;
    init_d = init_q;
    tog_d  = 1'b0;
    if (clear) begin
      act_d  = 1'b0;
      dir_d  = 1'b0;
      init_d = 1'b0;
    end else if (release_i) begin
      act_d  = 1'b1;
      dir_d  = ODD;
      init_d = ODD;
    end else if (act_q) begin
      if (init_q) begin
        if (run_en) begin
          tog_d  = 1'b1;
          init_d = 1'b0;
        end
      end else if (check_en && hit) begin
        tog_d = 1'b1;
        dir_d = ~dir_q;
      end
    end
  end

  // Lane state registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      act_q  <= 1'b0;
      dir_q  <= 1'b0;
      tog_q  <= 1'b0;
      init_q <= 1'b0;
    end else begin
      act_q  <= act_d;
      dir_q  <= dir_d;
      tog_q  <= tog_d;
      init_q <= init_d;
    end
  end

  assign active_o = act_q;
  assign toggle_o = tog_q;
endmodule

module rope_sequencer #(
  parameter int NUM_ROPES        = 4,
  parameter int LEFT_LIMIT       = 32,
  parameter int RIGHT_LIMIT      = 576,
  parameter int ROPE_WIDTH       = 16,
  parameter int BASE_SPEED       = 20,
  parameter int SPEED_STEP       = 8,
  parameter int SPAWN_GAP_FRAMES = 15
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     startOfFrame,
  input  logic                     levelStart,
  input  logic [1:0]               level,
  input  logic                     pauseReq,
  input  logic [11*NUM_ROPES-1:0]  ropeX,
  output logic [NUM_ROPES-1:0]     ropeLoadN,
  output logic [7*NUM_ROPES-1:0]   ropeSpeed,
  output logic [11*NUM_ROPES-1:0]  ropeInitX,
  output logic [NUM_ROPES-1:0]     ropeFrame,
  output logic [NUM_ROPES-1:0]     dirToggle,
  output logic [NUM_ROPES-1:0]     activeMask,
  output logic [1:0]               seqState
);
  typedef enum logic [1:0] {IDLE = 2'd0, SPAWN = 2'd1, RUN = 2'd2, PAUSE = 2'd3} st_t;

  localparam int CW = $clog2(SPAWN_GAP_FRAMES + 1);
  localparam int IW = (NUM_ROPES > 1) ? $clog2(NUM_ROPES) : 1;

  st_t           st_q, st_d, resume_q, resume_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          entry_q, entry_d;
  logic [1:0]    level_q, level_d;
  logic          rel_en, last;
  logic          check_en, run_en;
  logic [7:0]    spd_sum;
  logic [6:0]    spd;

  // Sequencer next state: level restart, spawn timing, pause/resume.
  // The first release happens on the cycle after a level restart, even if a pause is
  // requested, so the ropes are dropped for exactly one cycle.
  always_comb begin
    st_d     = st_q;
    resume_d = resume_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    entry_d  = entry_q;
    level_d  = level_q;
    rel_en   = 1'b0;
    last     = (idx_q == IW'(NUM_ROPES - 1));
    if (levelStart) begin
      st_d    = SPAWN;
      cnt_d   = '0;
      idx_d   = '0;
      entry_d = 1'b1;
      level_d = level;
    end else begin
      case (st_q)
        SPAWN: begin
          if (entry_q) begin
            rel_en  = 1'b1;
            entry_d = 1'b0;
          end else if (startOfFrame) begin
            if (cnt_q == CW'(SPAWN_GAP_FRAMES - 1)) begin
              rel_en = 1'b1;
              cnt_d  = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          if (rel_en) begin
            if (last) st_d = RUN;
            else      idx_d = idx_q + 1'b1;
          end
          if (pauseReq) begin
            resume_d = (rel_en && last) ? RUN : SPAWN;
            st_d     = PAUSE;
          end
        end
        RUN: begin
          if (pauseReq) begin
            resume_d = RUN;
            st_d     = PAUSE;
          end
        end
        PAUSE: begin
          if (!pauseReq) st_d = resume_q;
        end
        default: ;
      endcase
    end
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      st_q     <= IDLE;
      resume_q <= SPAWN;
      cnt_q    <= '0;
      idx_q    <= '0;
      entry_q  <= 1'b0;
      level_q  <= 2'd0;
    end else begin
      st_q     <= st_d;
      resume_q <= resume_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      entry_q  <= entry_d;
      level_q  <= level_d;
    end
  end

  // Shared speed: 8-bit sum saturated to the mover's 7-bit range.
  always_comb begin
    spd_sum = 8'(BASE_SPEED) + 8'(SPEED_STEP) * {6'd0, level_q};
    spd     = spd_sum[7] ? 7'd127 : spd_sum[6:0];
  end

  assign check_en  = startOfFrame && ((st_q == SPAWN) || (st_q == RUN));
  assign run_en    = (st_q != PAUSE);
  assign ropeLoadN = activeMask;
  assign ropeFrame = {NUM_ROPES{startOfFrame && run_en}} & activeMask;
  assign seqState  = st_q;
  assign ropeSpeed = {NUM_ROPES{spd}};

  for (genvar i = 0; i < NUM_ROPES; i++) begin : g_lane
    assign ropeInitX[11*i +: 11] =
      11'(LEFT_LIMIT + i * ((RIGHT_LIMIT - LEFT_LIMIT) / NUM_ROPES));

    rope_lane #(
      .ODD        (1'(i % 2)),
      .LEFT_LIMIT (LEFT_LIMIT),
      .RIGHT_BOUND(RIGHT_LIMIT - ROPE_WIDTH)
    ) u_lane (
      .clk      (clk),
      .resetN   (resetN),
      .clear    (levelStart),
      .release_i(rel_en && (idx_q == IW'(i))),
      .run_en   (run_en),
      .check_en (check_en),
      .x        (ropeX[11*i +: 11]),
      .active_o (activeMask[i]),
      .toggle_o (dirToggle[i])
    );
  end
endmodule

// File: tb/tb_rope_sequencer.sv
// Bench for rope_sequencer: directed phases with randomized rope positions and
// frame spacing. A release-schedule model built from the game rules predicts
// every cycle's outputs.
module tb_rope_sequencer;
  localparam int N = 4, GAP = 15, LL = 32, RL = 576, RW = 16;

  logic clk = 1'b0;
  logic resetN, sof, ls, pr;
  logic [1:0] level;
  logic [11*N-1:0] ropeX;
  logic [N-1:0] ropeLoadN, ropeFrame, dirToggle, activeMask;
  logic [7*N-1:0] ropeSpeed;
  logic [11*N-1:0] ropeInitX;
  logic [1:0] seqState;
  logic [N-1:0] s_loadN, s_frame, s_tog, s_act;
  logic [7*N-1:0] s_speed;
  logic [11*N-1:0] s_initx;
  logic [1:0] s_state;

  int tests = 0, fails = 0;

  // model: state 0..3 as named by the game rules, releases by frame threshold
  int m_state = 0, m_resume = 1, m_live = 0, m_rel = 0;
  bit m_entry = 0;
  bit m_act[N], m_dir[N], m_pend[N];
  int rx[N];
  int frame_no = 0;
  int rel_frame[N];
  logic [N-1:0] prev_load = '0, sof_tog = '0;
  bit pr_cur = 0;

  always #5 clk = ~clk;

  rope_sequencer u_dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .levelStart(ls), .level(level),
    .pauseReq(pr), .ropeX(ropeX), .ropeLoadN(ropeLoadN), .ropeSpeed(ropeSpeed),
    .ropeInitX(ropeInitX), .ropeFrame(ropeFrame), .dirToggle(dirToggle),
    .activeMask(activeMask), .seqState(seqState)
  );

  rope_sequencer #(.BASE_SPEED(120)) u_sat (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .levelStart(ls), .level(level),
    .pauseReq(pr), .ropeX(ropeX), .ropeLoadN(s_loadN), .ropeSpeed(s_speed),
    .ropeInitX(s_initx), .ropeFrame(s_frame), .dirToggle(s_tog),
    .activeMask(s_act), .seqState(s_state)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_speed(input int base, input int lvl);
    int s;
    s = (base + lvl * 8) % 256;
    return (s > 127) ? 127 : s;
  endfunction

  function automatic logic [N-1:0] pack_act();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_act[i];
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_act[i] = 0; m_dir[i] = 0; m_pend[i] = 0;
    end
  endtask

  // One clock: drive inputs, check combinational frame gate, advance model, check registers.
  task automatic step(input bit s, input bit l, input bit p);
    logic [N-1:0] expf, tog_n;
    bit rel;
    sof = s; ls = l; pr = p;
    for (int i = 0; i < N; i++) ropeX[11*i +: 11] = 11'(rx[i]);
    #1;
    for (int i = 0; i < N; i++) expf[i] = s && m_act[i] && (m_state != 3);
    chk("ropeFrame", ropeFrame, expf);
    tog_n = '0;
    rel = 0;
    if (l) begin
      m_state = 1; m_entry = 1; m_live = 0; m_rel = 0;
      model_clear();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m_act[i] && m_state != 3) begin
          if (m_pend[i]) begin
            tog_n[i] = 1; m_pend[i] = 0;
          end else if (s && (m_state == 1 || m_state == 2) &&
                       (m_dir[i] ? (rx[i] <= LL) : (rx[i] >= RL - RW))) begin
            tog_n[i] = 1; m_dir[i] = !m_dir[i];
          end
        end
      end
      case (m_state)
        1: begin
          if (m_entry) begin
            rel = 1; m_entry = 0;
          end else if (s) begin
            m_live++;
            if (m_live == m_rel * GAP) rel = 1;
          end
          if (rel) begin
            m_act[m_rel] = 1; m_dir[m_rel] = (m_rel % 2) == 1; m_pend[m_rel] = (m_rel % 2) == 1;
            m_rel++;
            if (m_rel == N) m_state = 2;
          end
          if (p) begin m_resume = m_state; m_state = 3; end
        end
        2: if (p) begin m_resume = 2; m_state = 3; end
        3: if (!p) m_state = m_resume;
        default: ;
      endcase
    end
    @(posedge clk); #1;
    if (s) begin frame_no++; sof_tog = dirToggle; end
    chk("ropeLoadN", ropeLoadN, pack_act());
    chk("activeMask", activeMask, pack_act());
    chk("dirToggle", dirToggle, tog_n);
    chk("seqState", seqState, m_state);
    for (int i = 0; i < N; i++) if (ropeLoadN[i] && !prev_load[i]) rel_frame[i] = frame_no;
    prev_load = ropeLoadN;
  endtask

  task automatic frame(input int gap);
    step(1'b1, 1'b0, pr_cur);
    for (int k = 1; k < gap; k++) step(1'b0, 1'b0, pr_cur);
  endtask

  task automatic mid_x();
    for (int i = 0; i < N; i++) rx[i] = int'($urandom_range(100, 500));
  endtask

  task automatic check_speed(input int lvl);
    logic [7*N-1:0] e, es;
    for (int i = 0; i < N; i++) begin
      e[7*i +: 7]  = 7'(exp_speed(20, lvl));
      es[7*i +: 7] = 7'(exp_speed(120, lvl));
    end
    chk("ropeSpeed", ropeSpeed, e);
    chk("ropeSpeed_sat", s_speed, es);
  endtask

  initial begin
    resetN = 1'b0; sof = 0; ls = 0; pr = 0; level = 2'd0; ropeX = '0;
    for (int i = 0; i < N; i++) begin rx[i] = 200; rel_frame[i] = 0; end
    model_clear();
    #12;
    chk("rst_loadN", ropeLoadN, 0);
    chk("rst_active", activeMask, 0);
    chk("rst_tog", dirToggle, 0);
    chk("rst_frame", ropeFrame, 0);
    chk("rst_state", seqState, 0);
    check_speed(0);
    @(posedge clk); #1;
    resetN = 1'b1;

    // idle frames: nothing released
    frame(3); frame(4);
    for (int i = 0; i < N; i++)
      chk("initX", ropeInitX[11*i +: 11], LL + i * ((RL - LL) / N));

    // level 0 spawn sequence
    level = 2'd0;
    step(0, 1, 0);
    step(0, 0, 0);
    check_speed(0);
    for (int f = 0; f < 50; f++) begin
      mid_x();
      frame(int'($urandom_range(2, 5)));
    end
    chk("rel1_gap", rel_frame[1] - rel_frame[0], GAP);
    chk("rel2_gap", rel_frame[2] - rel_frame[0], 2 * GAP);
    chk("rel3_gap", rel_frame[3] - rel_frame[0], 3 * GAP);
    chk("run_state", seqState, 2);

    // right limit boundary on rope 0, then back at the left limit; rope 1 left limit
    rx[0] = 559; frame(3); chk("tog559", sof_tog[0], 0);
    rx[0] = 560; frame(3); chk("tog560", sof_tog[0], 1);
    rx[0] = 300; frame(3); chk("tog300", sof_tog[0], 0);
    rx[0] = 32;  frame(3); chk("tog32", sof_tog[0], 1);
    rx[0] = 300;
    rx[1] = 33;  frame(3); chk("tog1_33", sof_tog[1], 0);
    rx[1] = 32;  frame(3); chk("tog1_32", sof_tog[1], 1);
    rx[1] = 300; frame(3);

    // random positions across and beyond the playfield
    for (int f = 0; f < 60; f++) begin
      for (int i = 0; i < N; i++) rx[i] = int'($urandom_range(0, 720)) - 20;
      frame(int'($urandom_range(2, 5)));
    end

    // level 3 with a 40-frame pause after rope 1 release
    mid_x();
    level = 2'd3;
    step(0, 1, 0);
    step(0, 0, 0);
    check_speed(3);
    for (int f = 0; f < 18; f++) frame(3);
    pr_cur = 1; step(0, 0, 1);
    rx[0] = 600; rx[1] = 10;
    for (int f = 0; f < 40; f++) frame(int'($urandom_range(2, 4)));
    chk("pause_state", seqState, 3);
    mid_x();
    pr_cur = 0; step(0, 0, 0);
    for (int f = 0; f < 35; f++) frame(3);
    chk("pause_rel2_gap", rel_frame[2] - rel_frame[1], GAP + 40);
    chk("pause_rel3_gap", rel_frame[3] - rel_frame[2], GAP);

    // restart with pause held: one-cycle drop, then PAUSE
    level = 2'd1;
    step(0, 1, 1);
    chk("restart_drop", ropeLoadN, 0);
    pr_cur = 1; step(0, 0, 1);
    chk("restart_pause", seqState, 3);
    chk("restart_rope0", ropeLoadN, 1);
    check_speed(1);
    pr_cur = 0; step(0, 0, 0);
    for (int f = 0; f < 47; f++) begin mid_x(); frame(3); end
    chk("run_again", seqState, 2);

    // asynchronous reset mid-RUN
    sof = 0;
    #2 resetN = 1'b0;
    #1;
    chk("arst_loadN", ropeLoadN, 0);
    chk("arst_active", activeMask, 0);
    chk("arst_tog", dirToggle, 0);
    chk("arst_state", seqState, 0);
    check_speed(0);
    m_state = 0; m_entry = 0; m_live = 0; m_rel = 0;
    model_clear();
    prev_load = '0;
    @(posedge clk); #1;
    resetN = 1'b1;
    frame(3); frame(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
